// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: data-source select, load size and FSM states.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        DIN_PC4 = 2'b00,
        DIN_ALU = 2'b01,
        DIN_FPU = 2'b10,
        DIN_MEM = 2'b11
    } din_src_e;

    // 2'b11 has no name of its own; the load path treats it as a word access
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } mem_size_e;

    typedef enum logic {
        WB_SINGLE  = 1'b0,
        WB_PAIR_LO = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bundle plus the register-file write port and forwarding path.
interface writeback_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 6,
    parameter int CNT_W   = 32
);
    logic [DATA_W-1:0]  NextMEMDout;
    logic [DATA_W-1:0]  NextALUOut;
    logic [DATA_W-1:0]  NextFPUOut;
    logic [DATA_W-1:0]  NextFPUOutLo;
    logic [DATA_W-1:0]  NextPCPlusFour;
    logic [1:0]         NextDInSrc;
    logic               NextRegWE;
    logic [RADDR_W-1:0] NextRegWAddr;
    logic [1:0]         NextMEMSize;
    logic               NextExtMEM;
    logic               NextDouble;

    logic               RegWE;
    logic [RADDR_W-1:0] RegWAddr;
    logic [DATA_W-1:0]  RegWData;
    logic [DATA_W-1:0]  WBRegB;
    logic               PairStall;
    logic [CNT_W-1:0]   RetireCount;

    modport master (
        output NextMEMDout, NextALUOut, NextFPUOut, NextFPUOutLo, NextPCPlusFour,
               NextDInSrc, NextRegWE, NextRegWAddr, NextMEMSize, NextExtMEM, NextDouble,
        input  RegWE, RegWAddr, RegWData, WBRegB, PairStall, RetireCount
    );

    modport slave (
        input  NextMEMDout, NextALUOut, NextFPUOut, NextFPUOutLo, NextPCPlusFour,
               NextDInSrc, NextRegWE, NextRegWAddr, NextMEMSize, NextExtMEM, NextDouble,
        output RegWE, RegWAddr, RegWData, WBRegB, PairStall, RetireCount
    );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Big-endian load formatter: picks the addressed byte/halfword from a 32-bit word and extends it.
import writeback_stage_pkg::*;

module load_align #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              ext,
    output logic [DATA_W-1:0] formatted
);

    function automatic logic [DATA_W-1:0] extend8(input logic [7:0] b, input logic sgn);
        logic signed [7:0] s;
        s = b;
        return sgn ? DATA_W'(signed'(s)) : DATA_W'(b);
    endfunction

    function automatic logic [DATA_W-1:0] extend16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] s;
        s = h;
        return sgn ? DATA_W'(signed'(s)) : DATA_W'(h);
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 addresses the most significant byte; a misaligned half ignores offset[0]
    always_comb begin
        byte_sel = word[31:24];
        case (offset)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        formatted = word;
        case (size)
            SZ_HALF: formatted = extend16(half_sel, ext);
            SZ_BYTE: formatted = extend8(byte_sel, ext);
            default: formatted = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// WB pipeline stage: latches memory-stage results, formats loads, splits FPU doubles into two writes.
// Optional retire counter built when WB_RETIRE_COUNT_EN is defined.
import writeback_stage_pkg::*;

module writeback_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            reset,
    writeback_stage_if.slave wb
);

    logic [DATA_W-1:0]  mem_dout_p0;
    logic [DATA_W-1:0]  alu_out_p0;
    logic [DATA_W-1:0]  fpu_out_p0;
    logic [DATA_W-1:0]  fpu_lo_p0;
    logic [DATA_W-1:0]  pc4_p0;
    logic [1:0]         din_src_p0;
    logic               we_p0;
    logic [RADDR_W-1:0] waddr_p0;
    logic [1:0]         mem_size_p0;
    logic               ext_p0;
    logic               double_p0;

    wb_state_e          state_q;
    wb_state_e          state_d;
    logic               pair_start;
    logic               load_en;
    logic [DATA_W-1:0]  load_data;
    logic [DATA_W-1:0]  single_data;

    logic               reg_we;
    logic [RADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0]  reg_wdata;
    logic               pair_stall;

    assign pair_start = (state_q == WB_SINGLE) && we_p0 && double_p0 && (din_src_p0 == DIN_FPU);
    // Hold the double during its first half; reload as soon as the low-word write is under way
    assign load_en    = !pair_start;

    // ---- MEM -> WB pipeline register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_dout_p0 <= '0;
            alu_out_p0  <= '0;
            fpu_out_p0  <= '0;
            fpu_lo_p0   <= '0;
            pc4_p0      <= '0;
            din_src_p0  <= DIN_PC4;
            we_p0       <= 1'b0;
            waddr_p0    <= '0;
            mem_size_p0 <= SZ_WORD;
            ext_p0      <= 1'b0;
            double_p0   <= 1'b0;
        end else if (load_en) begin
            mem_dout_p0 <= wb.NextMEMDout;
            alu_out_p0  <= wb.NextALUOut;
            fpu_out_p0  <= wb.NextFPUOut;
            fpu_lo_p0   <= wb.NextFPUOutLo;
            pc4_p0      <= wb.NextPCPlusFour;
            din_src_p0  <= wb.NextDInSrc;
            we_p0       <= wb.NextRegWE;
            waddr_p0    <= wb.NextRegWAddr;
            mem_size_p0 <= wb.NextMEMSize;
            ext_p0      <= wb.NextExtMEM;
            double_p0   <= wb.NextDouble;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= WB_SINGLE;
        else        state_q <= state_d;
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .word      (mem_dout_p0),
        .offset    (alu_out_p0[1:0]),
        .size      (mem_size_p0),
        .ext       (ext_p0),
        .formatted (load_data)
    );

    always_comb begin
        single_data = pc4_p0;
        case (din_src_e'(din_src_p0))
            DIN_PC4: single_data = pc4_p0;
            DIN_ALU: single_data = alu_out_p0;
            DIN_FPU: single_data = fpu_out_p0;
            DIN_MEM: single_data = load_data;
            default: single_data = pc4_p0;
        endcase
    end

    // ---- WB outputs and pair sequencing ----
    always_comb begin
        state_d    = WB_SINGLE;
        reg_we     = we_p0;
        reg_waddr  = waddr_p0;
        reg_wdata  = single_data;
        pair_stall = 1'b0;
        case (state_q)
            WB_SINGLE: begin
                if (pair_start) begin
                    reg_waddr  = {waddr_p0[RADDR_W-1:1], 1'b0};
                    reg_wdata  = fpu_out_p0;
                    pair_stall = 1'b1;
                    state_d    = WB_PAIR_LO;
                end
            end
            WB_PAIR_LO: begin
                reg_we    = 1'b1;
                reg_waddr = {waddr_p0[RADDR_W-1:1], 1'b1};
                reg_wdata = fpu_lo_p0;
                state_d   = WB_SINGLE;
            end
            default: state_d = WB_SINGLE;
        endcase
    end

    assign wb.RegWE     = reg_we;
    assign wb.RegWAddr  = reg_waddr;
    assign wb.RegWData  = reg_wdata;
    assign wb.WBRegB    = reg_wdata;
    assign wb.PairStall = pair_stall;

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retire_q;

    // A double retires once, on its first-half cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retire_q <= '0;
        else if ((state_q == WB_SINGLE) && we_p0)
            retire_q <= retire_q + CNT_W'(1);
    end

    assign wb.RetireCount = retire_q;
`else
    assign wb.RetireCount = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, load formatting, double pairs, back-to-back singles.
`timescale 1ns/1ps
module tb_writeback_stage;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 6;
    localparam int CNT_W   = 32;
`ifdef WB_RETIRE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    writeback_stage_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) wbif ();

    writeback_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        wbif.NextMEMDout    = '0;
        wbif.NextALUOut     = '0;
        wbif.NextFPUOut     = '0;
        wbif.NextFPUOutLo   = '0;
        wbif.NextPCPlusFour = '0;
        wbif.NextDInSrc     = 2'b00;
        wbif.NextRegWE      = 1'b0;
        wbif.NextRegWAddr   = '0;
        wbif.NextMEMSize    = 2'b00;
        wbif.NextExtMEM     = 1'b0;
        wbif.NextDouble     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [1:0] size, input logic ext);
        set_idle();
        wbif.NextMEMDout  = 32'h12F45678;
        wbif.NextALUOut   = addr;
        wbif.NextMEMSize  = size;
        wbif.NextExtMEM   = ext;
        wbif.NextDInSrc   = 2'b11;
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd5;
    endtask

    task automatic set_double();
        set_idle();
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd37;
        wbif.NextFPUOut   = 32'hAAAA0000;
        wbif.NextFPUOutLo = 32'h0000BBBB;
        wbif.NextDouble   = 1'b1;
        wbif.NextDInSrc   = 2'b10;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        set_idle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd12;
        wbif.NextDInSrc   = 2'b01;
        wbif.NextALUOut   = 32'h1234;
        step();
        vectors++;
        if (wbif.RegWData !== 32'h1234) begin
            miscompares++; $display("FAIL pre_reset_data got %h want %h", wbif.RegWData, 32'h1234);
        end
        set_idle();
        reset = 1'b0;
        #1;
        vectors++;
        if (wbif.RegWE !== 1'b0 || wbif.RegWAddr !== 6'd0 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_low_ctrl got we=%b addr=%0d stall=%b want 0 0 0",
                     wbif.RegWE, wbif.RegWAddr, wbif.PairStall);
        end
        vectors++;
        if (wbif.RegWData !== 32'h0 || wbif.RetireCount !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_low_data got data=%h cnt=%0d want 0 0", wbif.RegWData, wbif.RetireCount);
        end
        step();
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (wbif.RegWE !== 1'b0 || wbif.RegWAddr !== 6'd0 || wbif.RetireCount !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release got we=%b addr=%0d cnt=%0d want 0 0 0",
                     wbif.RegWE, wbif.RegWAddr, wbif.RetireCount);
        end
    endtask

    task automatic test_load_byte();
        set_load(32'h00000001, 2'b10, 1'b1);
        step();
        vectors++;
        if (wbif.RegWData !== 32'hFFFFFFF4 || wbif.WBRegB !== 32'hFFFFFFF4) begin
            miscompares++;
            $display("FAIL byte_sext got %h/%h want FFFFFFF4", wbif.RegWData, wbif.WBRegB);
        end
        set_load(32'h00000001, 2'b10, 1'b0);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h000000F4) begin
            miscompares++; $display("FAIL byte_zext got %h want 000000F4", wbif.RegWData);
        end
        set_load(32'h00000000, 2'b10, 1'b1);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h00000012) begin
            miscompares++; $display("FAIL byte_off0 got %h want 00000012", wbif.RegWData);
        end
        set_load(32'h00000003, 2'b10, 1'b0);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h00000078) begin
            miscompares++; $display("FAIL byte_off3 got %h want 00000078", wbif.RegWData);
        end
    endtask

    task automatic test_load_half();
        set_load(32'h00000002, 2'b01, 1'b1);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h00005678) begin
            miscompares++; $display("FAIL half_off2 got %h want 00005678", wbif.RegWData);
        end
        set_load(32'h00000003, 2'b01, 1'b1);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h00005678) begin
            miscompares++; $display("FAIL half_misaligned got %h want 00005678", wbif.RegWData);
        end
        set_load(32'h00000000, 2'b01, 1'b1);
        wbif.NextMEMDout = 32'h8001ABCD;
        step();
        vectors++;
        if (wbif.RegWData !== 32'hFFFF8001) begin
            miscompares++; $display("FAIL half_sext_hi got %h want FFFF8001", wbif.RegWData);
        end
    endtask

    task automatic test_load_word();
        set_load(32'h00000003, 2'b00, 1'b1);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h12F45678) begin
            miscompares++; $display("FAIL word_off3 got %h want 12F45678", wbif.RegWData);
        end
        set_load(32'h00000001, 2'b11, 1'b1);
        step();
        vectors++;
        if (wbif.RegWData !== 32'h12F45678) begin
            miscompares++; $display("FAIL word_size11 got %h want 12F45678", wbif.RegWData);
        end
    endtask

    task automatic test_double();
        pulse_reset();
        set_double();
        step();
        vectors++;
        if (wbif.RegWE !== 1'b1 || wbif.RegWAddr !== 6'd36 || wbif.RegWData !== 32'hAAAA0000 ||
            wbif.PairStall !== 1'b1) begin
            miscompares++;
            $display("FAIL double_hi got we=%b addr=%0d data=%h stall=%b want 1 36 AAAA0000 1",
                     wbif.RegWE, wbif.RegWAddr, wbif.RegWData, wbif.PairStall);
        end
        set_idle();
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd3;
        wbif.NextDInSrc   = 2'b01;
        wbif.NextALUOut   = 32'h77;
        step();
        vectors++;
        if (wbif.RegWE !== 1'b1 || wbif.RegWAddr !== 6'd37 || wbif.RegWData !== 32'h0000BBBB ||
            wbif.PairStall !== 1'b0 || wbif.WBRegB !== 32'h0000BBBB) begin
            miscompares++;
            $display("FAIL double_lo got we=%b addr=%0d data=%h stall=%b want 1 37 0000BBBB 0",
                     wbif.RegWE, wbif.RegWAddr, wbif.RegWData, wbif.PairStall);
        end
        step();
        vectors++;
        if (wbif.RegWAddr !== 6'd3 || wbif.RegWData !== 32'h77 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL after_pair got addr=%0d data=%h stall=%b want 3 00000077 0",
                     wbif.RegWAddr, wbif.RegWData, wbif.PairStall);
        end
        vectors++;
        if (wbif.RetireCount !== (CNT_ON ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL retire_count got %0d want %0d", wbif.RetireCount, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_pair();
        set_double();
        step();
        vectors++;
        if (wbif.PairStall !== 1'b1) begin
            miscompares++; $display("FAIL midpair_stall_pre got %b want 1", wbif.PairStall);
        end
        set_idle();
        reset = 1'b0;
        #1;
        vectors++;
        if (wbif.PairStall !== 1'b0 || wbif.RegWE !== 1'b0 || wbif.RegWAddr !== 6'd0) begin
            miscompares++;
            $display("FAIL midpair_reset got stall=%b we=%b addr=%0d want 0 0 0",
                     wbif.PairStall, wbif.RegWE, wbif.RegWAddr);
        end
        step();
        #1;
        reset = 1'b1;
        step();
        vectors++;
        if (wbif.RegWE !== 1'b0 || wbif.RegWAddr !== 6'd0 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL midpair_no_lo got we=%b addr=%0d stall=%b want 0 0 0",
                     wbif.RegWE, wbif.RegWAddr, wbif.PairStall);
        end
        set_idle();
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd9;
        wbif.NextDInSrc   = 2'b01;
        wbif.NextALUOut   = 32'h9;
        step();
        vectors++;
        if (wbif.RegWAddr !== 6'd9 || wbif.RegWData !== 32'h9 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL midpair_single got addr=%0d data=%h stall=%b want 9 00000009 0",
                     wbif.RegWAddr, wbif.RegWData, wbif.PairStall);
        end
    endtask

    task automatic test_double_ignored();
        set_idle();
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd37;
        wbif.NextDouble   = 1'b1;
        wbif.NextDInSrc   = 2'b01;
        wbif.NextALUOut   = 32'h55;
        step();
        vectors++;
        if (wbif.RegWAddr !== 6'd37 || wbif.RegWData !== 32'h55 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL double_non_fpu got addr=%0d data=%h stall=%b want 37 00000055 0",
                     wbif.RegWAddr, wbif.RegWData, wbif.PairStall);
        end
        set_double();
        wbif.NextRegWE = 1'b0;
        step();
        vectors++;
        if (wbif.RegWE !== 1'b0 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL double_bubble got we=%b stall=%b want 0 0", wbif.RegWE, wbif.PairStall);
        end
        set_idle();
        step();
        vectors++;
        if (wbif.RegWE !== 1'b0 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_no_lo got we=%b stall=%b want 0 0", wbif.RegWE, wbif.PairStall);
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        wbif.NextRegWE    = 1'b1;
        wbif.NextRegWAddr = 6'd1;
        wbif.NextDInSrc   = 2'b01;
        wbif.NextALUOut   = 32'h5;
        wbif.NextPCPlusFour = 32'h200;
        step();
        vectors++;
        if (wbif.RegWData !== 32'h5 || wbif.WBRegB !== 32'h5 || wbif.PairStall !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_alu got data=%h fwd=%h stall=%b want 00000005 00000005 0",
                     wbif.RegWData, wbif.WBRegB, wbif.PairStall);
        end
        wbif.NextRegWAddr   = 6'd31;
        wbif.NextDInSrc     = 2'b00;
        wbif.NextALUOut     = 32'h999;
        wbif.NextPCPlusFour = 32'h104;
        step();
        vectors++;
        if (wbif.RegWData !== 32'h104 || wbif.WBRegB !== 32'h104 || wbif.PairStall !== 1'b0 ||
            wbif.RegWAddr !== 6'd31) begin
            miscompares++;
            $display("FAIL b2b_link got data=%h fwd=%h stall=%b addr=%0d want 00000104 00000104 0 31",
                     wbif.RegWData, wbif.WBRegB, wbif.PairStall, wbif.RegWAddr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        test_reset();
        test_load_byte();
        test_load_half();
        test_load_word();
        test_double();
        test_reset_mid_pair();
        test_double_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final (WB) pipeline stage, directly downstream of the memory stage. It holds the WB pipeline register and formats load data for byte, halfword or word accesses, big-endian. It selects the register-file write data and drives the register-file write port plus the forwarding value back to the memory stage. A 2-state FSM splits double-precision FPU results into two consecutive register writes and stalls the upstream stages for one cycle.

Parameters:
DATA_W, 32, datapath width
RADDR_W, 6, register write address width (int + FP file)
CNT_W, 32, retire counter width (optional feature only)

Ports:
clk  in  1  clock, posedge
reset  in  1  asynchronous, active-low (asserted at 0)
NextMEMDout  in  DATA_W  raw data-memory read word
NextALUOut  in  DATA_W  ALU result; also the memory address
NextFPUOut  in  DATA_W  FPU result, high word for doubles
NextFPUOutLo  in  DATA_W  FPU low word for doubles
NextPCPlusFour  in  DATA_W  link value
NextDInSrc  in  2  00 PC+4, 01 ALU, 10 FPU, 11 formatted load
NextRegWE  in  1  write enable
NextRegWAddr  in  RADDR_W  destination register
NextMEMSize  in  2  00 word, 01 half, 10 byte, 11 treated as word
NextExtMEM  in  1  1 = sign-extend load
NextDouble  in  1  FPU result is 64-bit
RegWE  out  1  register-file write enable
RegWAddr  out  RADDR_W  register-file write address
RegWData  out  DATA_W  register-file write data
WBRegB  out  DATA_W  forward value to the memory stage (equals RegWData)
PairStall  out  1  hold all upstream stages this cycle
RetireCount  out  CNT_W  retired instructions (optional feature only)

Behaviour:
- Pipeline register: loads all Next* inputs on posedge clk when state == SINGLE. It holds when the next state is PAIR_LO.
- Reset (reset == 0, async): pipeline register cleared (RegWE 0, addr 0, DInSrc 00, Double 0). State = SINGLE. PairStall 0. RetireCount 0. RegWData 0 follows from the cleared register.
- Latency: outputs are combinational from the WB register, so they are valid one cycle after the memory stage presents Next*.
- Load format: byte offset = latched ALUOut[30:31], bit 0 is the MSB.
  - Word: data passes through unchanged; offset ignored.
  - Half: offset[0]=0 selects bits [0:15], 1 selects [16:31].
  - Byte: offset 0..3 selects bits [0:7], [8:15], [16:23], [24:31].
  - Extension: sign-extend if Ext=1, else zero-extend.
  - Misaligned half (offset bit 31 = 1): the low bit is ignored.
- Data select: per DInSrc (00/01/10/11) as in the port list.
- FSM, SINGLE:
  - If latched RegWE & Double & DInSrc==10, the stage is in the first half of a pair:
    - RegWAddr = addr with LSB cleared; RegWData = FPUOut (high word); PairStall=1.
    - Next state = PAIR_LO.
  - Otherwise: normal single write, PairStall=0.
- FSM, PAIR_LO:
  - RegWAddr = addr with LSB set; RegWData = latched FPUOutLo; RegWE=1; PairStall=0.
  - Next state = SINGLE, and the register loads the new Next* at that edge.
- Double with DInSrc != 10: Double is ignored and the instruction writes as a single.
- RegWE=0 with Double=1: no pair; the instruction is a bubble.
- Odd destination with Double: the LSB is forced as above (pair = even/odd registers).
- Reset mid-pair: returns to SINGLE immediately; the second write is lost and PairStall drops asynchronously.
- Upstream contract: while PairStall=1, upstream holds its outputs and must not issue a memory write.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined: RetireCount increments by 1 per retired instruction (any non-reset cycle with latched RegWE=1 in SINGLE state). The PAIR_LO cycle does not count, so a double counts once. The counter wraps at 2^CNT_W. Reset value is 0.
- Undefined: the counter is not built; RetireCount is tied to 0.

Decomposition:
- Shared package: DInSrc encodings (DIN_PC4, DIN_ALU, DIN_FPU, DIN_MEM), MemSize encodings (SZ_WORD, SZ_HALF, SZ_BYTE), and the FSM state type (WB_SINGLE, WB_PAIR_LO).
- One sub-module: load_align (combinational inputs word, offset, size, ext; output formatted word). It is reused by any future load path.

Test Plan:
- Reset low mid-stream -> RegWE=0, RegWAddr=0, PairStall=0, RetireCount=0 while low and after release.
- Byte load: MEMDout=32'h12F45678, ALUOut[30:31]=01, size=10, ext=1 -> RegWData=32'hFFFFFFF4. With ext=0 -> 32'h000000F4.
- Half load: same word, offset=10, size=01, ext=1 -> RegWData=32'h00005678. Word load -> 32'h12F45678 regardless of offset.
- Double FPU write: addr=6'd37, FPUOut=32'hAAAA0000, FPUOutLo=32'h0000BBBB, Double=1, DInSrc=10 ->
  - Cycle 1: addr 36, data AAAA0000, PairStall=1.
  - Cycle 2: addr 37, data 0000BBBB, PairStall=0.
  - Next instruction appears in cycle 3; RetireCount +1.
- Assert reset during the first cycle of a pair -> PairStall falls immediately, no write to the odd register, FSM in SINGLE.
- Back-to-back singles: ALU (DInSrc=01, 32'h5) then link (DInSrc=00, PC+4=32'h104) -> RegWData 5 then 104 on consecutive cycles; WBRegB matches; PairStall never asserted.
